// File: rtl/nonce_incrementer.sv
// nonce_incrementer: multi-cycle adder producing the next candidate nonce.
// The captured nonce is incremented by a zero-extended stride one CHUNK_W
// slice per clock, with the carry held in a register between slices so the
// per-cycle carry chain stays CHUNK_W bits long.
//
// Build option:
//   NONCE_INC_EARLY_EXIT_EN - when defined, the operation completes on the
//   first slice whose carry-out is zero, because every slice above it is
//   left unchanged. When undefined, every operation takes NUM_CHUNKS cycles.
module nonce_incrementer #(
   parameter int NONCE_W = 256,
   parameter int CHUNK_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [NONCE_W-1:0] nonce_i,
   input  logic [CHUNK_W-1:0] step_i,
   output logic [NONCE_W-1:0] incremented_nonce_o,
   output logic               ready_o,
   output logic               busy_o,
   output logic               wrap_o
);

   localparam int NUM_CHUNKS = NONCE_W / CHUNK_W;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ADD  = 1'b1
   } state_t;

   // Registered state
   state_t             state_r;
   logic [NONCE_W-1:0] work_r;
   logic [CHUNK_W-1:0] addend_r;
   logic               carry_r;
   logic [IDX_W-1:0]   idx_r;
   logic [NONCE_W-1:0] result_r;
   logic               ready_r;
   logic               wrap_r;

   // Next-state values
   state_t             state_s;
   logic [NONCE_W-1:0] work_s;
   logic [CHUNK_W-1:0] addend_s;
   logic               carry_s;
   logic [IDX_W-1:0]   idx_s;
   logic [NONCE_W-1:0] result_s;
   logic               ready_s;
   logic               wrap_s;

   // Slice datapath
   logic [CHUNK_W-1:0] slice_in_s;
   logic [CHUNK_W-1:0] slice_add_s;
   logic [CHUNK_W:0]   slice_sum_s;
   logic [NONCE_W-1:0] work_upd_s;
   logic               last_s;
   logic               done_s;

   // Add the current slice: stride only enters slice 0, carry enters every slice
   always_comb begin
      slice_in_s  = work_r[idx_r * CHUNK_W +: CHUNK_W];
      slice_add_s = (idx_r == {IDX_W{1'b0}}) ? addend_r : {CHUNK_W{1'b0}};
      slice_sum_s = {1'b0, slice_in_s} + {1'b0, slice_add_s}
                  + {{CHUNK_W{1'b0}}, carry_r};
      work_upd_s  = work_r;
      work_upd_s[idx_r * CHUNK_W +: CHUNK_W] = slice_sum_s[CHUNK_W-1:0];
      last_s      = (idx_r == IDX_W'(NUM_CHUNKS - 1));
`ifdef NONCE_INC_EARLY_EXIT_EN
      // No carry out means the upper slices are already final
      done_s      = last_s | ~slice_sum_s[CHUNK_W];
`else
      done_s      = last_s;
`endif
   end

   // Next-state and next-output logic of the IDLE/ADD controller
   always_comb begin
      state_s  = state_r;
      work_s   = work_r;
      addend_s = addend_r;
      carry_s  = carry_r;
      idx_s    = idx_r;
      result_s = result_r;
      ready_s  = ready_r;
      wrap_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               work_s   = nonce_i;
               addend_s = step_i;
               carry_s  = 1'b0;
               idx_s    = {IDX_W{1'b0}};
               ready_s  = 1'b0;
               state_s  = ST_ADD;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ADD: begin
            work_s  = work_upd_s;
            carry_s = slice_sum_s[CHUNK_W];
            if (done_s) begin
               // Carry-out of the final processed slice is the overflow;
               // an early exit only happens with a zero carry-out
               result_s = work_upd_s;
               ready_s  = 1'b1;
               wrap_s   = slice_sum_s[CHUNK_W];
               idx_s    = {IDX_W{1'b0}};
               state_s  = ST_IDLE;
            end else begin
               idx_s    = idx_r + IDX_W'(1);
               state_s  = ST_ADD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         work_r   <= {NONCE_W{1'b0}};
         addend_r <= {CHUNK_W{1'b0}};
         carry_r  <= 1'b0;
         idx_r    <= {IDX_W{1'b0}};
         result_r <= {NONCE_W{1'b0}};
         ready_r  <= 1'b0;
         wrap_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         work_r   <= work_s;
         addend_r <= addend_s;
         carry_r  <= carry_s;
         idx_r    <= idx_s;
         result_r <= result_s;
         ready_r  <= ready_s;
         wrap_r   <= wrap_s;
      end
   end

   assign incremented_nonce_o = result_r;
   assign ready_o             = ready_r;
   assign wrap_o              = wrap_r;
   assign busy_o              = (state_r == ST_ADD);

endmodule

// File: doc/nonce_incrementer.md
# nonce_incrementer

Multi-cycle adder that produces the next candidate nonce for the hashing core. It captures the current 256-bit nonce, adds a per-core stride in CHUNK_W-bit slices over successive cycles (one slice per cycle, carry rippled in a register), and presents the sum with a `ready_o` flag. The nonce register loads the result when it asserts its increment request while `ready_o` is high. Slicing keeps the carry chain short enough for the hashing clock.

## Interface

- Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `NONCE_W`, default 256, nonce width in bits; must be a multiple of `CHUNK_W`.
- `CHUNK_W`, default 32, slice width added per cycle. `NUM_CHUNKS = NONCE_W/CHUNK_W` (8 by default).

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset.
- `start_i`  in  1  begin an increment of `nonce_i` by `step_i`.
- `nonce_i`  in  NONCE_W  current nonce, sampled only on an accepted start.
- `step_i`  in  CHUNK_W  stride, zero-extended to NONCE_W, sampled only on an accepted start.
- `incremented_nonce_o`  out  NONCE_W  sum register.
- `ready_o`  out  1  `incremented_nonce_o` holds the completed sum of the last accepted start.
- `busy_o`  out  1  addition in progress.
- `wrap_o`  out  1  one-cycle pulse, coincident with the rising edge of `ready_o`, when the sum overflowed NONCE_W bits.

## Operation

- States:
  - IDLE: `busy_o=0`.
  - ADD: `busy_o=1`.
- Registers:
  - `work` (NONCE_W)
  - `addend` (CHUNK_W)
  - `carry` (1)
  - `idx` (0..NUM_CHUNKS-1)
- Start accepted only in IDLE.
  - On acceptance: `work<=nonce_i`, `addend<=step_i`, `carry<=0`, `idx<=0`, `ready_o<=0`, go to ADD.
  - `start_i` in ADD is ignored; the operation in progress is unaffected.
- Each ADD cycle:
  - slice `idx` becomes `work[idx] + (idx==0 ? addend : 0) + carry`, truncated to CHUNK_W.
  - `carry` <= carry-out of that slice.
  - `idx` increments.
- Completion (without early exit): after slice NUM_CHUNKS-1 is processed:
  - `incremented_nonce_o<=` final work;
  - `ready_o<=1`, go to IDLE;
  - `wrap_o<=` final carry-out for exactly one cycle.
- `ready_o` stays high until the next accepted start or reset. `incremented_nonce_o` holds its value until the next completion.
- Arithmetic is modulo 2^NONCE_W. All-ones + 1 gives zero with `wrap_o=1`.
- `step_i=0` is legal: the result equals `nonce_i`.
- Reset, including mid-operation:
  - state IDLE; `ready_o=0`, `busy_o=0`, `wrap_o=0`;
  - `incremented_nonce_o=0`, `work=0`, `idx=0`, `carry=0`;
  - any in-flight operation is discarded.

## Timing

- Start accepted at edge T → `busy_o=1` from T.
- Fixed latency: `ready_o` rises at edge T+NUM_CHUNKS (T+8 by default); `busy_o` falls on the same edge.
- Back-to-back: `start_i` held high re-accepts on the cycle `ready_o` is first high. `ready_o` is then high for one cycle, and the next result follows NUM_CHUNKS cycles later.
- Downstream may load `incremented_nonce_o` on any cycle `ready_o=1`. It must raise `start_i` again to obtain a fresh sum for the updated nonce.
- No combinational path from inputs to outputs.

## Configuration

- `NONCE_INC_EARLY_EXIT_EN`
  - Defined: after processing slice `idx`, if the carry-out is 0, the remaining slices are unchanged, so completion happens on that same edge. Outputs `incremented_nonce_o=work`, `ready_o=1`, `wrap_o=0`, IDLE.
    - Latency is 1 cycle when slice 0 does not carry, otherwise k+1 cycles for a carry through k slices.
    - Full ripple gives NUM_CHUNKS cycles.
  - Undefined: every operation takes exactly NUM_CHUNKS cycles regardless of carry.

## Test plan

1. Reset, then `nonce_i=5`, `step_i=3`, start → `ready_o` after 8 cycles (1 with early exit); `incremented_nonce_o=8`, `wrap_o=0`.
2. `nonce_i=0x0000_0001_FFFF_FFFF` (low 64 bits), `step_i=1` → result `0x0000_0002_0000_0000`. Latency is 8 cycles, or 2 with early exit.
3. `nonce_i` all-ones, `step_i=1` → result 0; `wrap_o` high for exactly one cycle, aligned with the rise of `ready_o`; latency 8 in both builds.
4. Pulse `start_i` at cycles 2 and 4 of an operation with `nonce_i` changed between them → pulses ignored; the result uses the originally captured operands.
5. Assert `rst_i` at cycle 3 of an operation → next cycle all outputs 0. A new start with `nonce_i=10`, `step_i=0` → result 10.
6. Hold `start_i=1` continuously with `step_i=7` from `nonce_i=0`, feeding each result back as `nonce_i` → successive results 7, 14, 21, each separated by NUM_CHUNKS+1 cycles in the fixed-latency build.
